// File: rtl/transpose_pingpong_buffer.sv
// Double-buffered DIM x DIM tile transposer: row-major in, column-major out.
// Two RAM banks ping-pong so one tile fills while the previous one drains.
module transpose_pingpong_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 8,
  parameter int ADDR_WIDTH = $clog2(DIM*DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam int DEPTH = DIM * DIM;
  localparam int CW    = $clog2(DIM);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DIM_A  = ADDR_WIDTH'(DIM);
  localparam logic [CW-1:0]         LAST_C = CW'(DIM - 1);

  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic [1:0]            bank_full_q, bank_full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         rd_i_q, rd_i_d;
  logic [CW-1:0]         rd_j_q, rd_j_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic                  wr_en, wr_done, rd_en, rd_done;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // in_ready depends only on registered bank state, never on in_valid.
  assign in_ready = !bank_full_q[wr_bank_q];
  assign wr_en    = in_valid && in_ready;
  assign wr_done  = wr_en && (wr_cnt_q == LAST_A);

  assign rd_en    = bank_full_q[rd_bank_q] && (!out_valid_q || out_ready);
  assign rd_done  = rd_en && (rd_i_q == LAST_C) && (rd_j_q == LAST_C);
  assign rd_addr  = ADDR_WIDTH'(rd_j_q) * DIM_A + ADDR_WIDTH'(rd_i_q);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_i_d      = rd_i_q;
    rd_j_d      = rd_j_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (wr_en) begin
      if (wr_done) begin
        wr_cnt_d               = '0;
        wr_bank_d              = !wr_bank_q;
        bank_full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
      end
    end

    // Write and read can only target different banks, so both bit updates hold.
    if (rd_en) begin
      if (rd_j_q == LAST_C) begin
        rd_j_d = '0;
        rd_i_d = (rd_i_q == LAST_C) ? '0 : rd_i_q + CW'(1);
      end else begin
        rd_j_d = rd_j_q + CW'(1);
      end
      if (rd_done) begin
        rd_bank_d              = !rd_bank_q;
        bank_full_d[rd_bank_q] = 1'b0;
      end
    end

    if (rd_en) begin
      out_valid_d = 1'b1;
      out_last_d  = rd_done;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_i_q      <= '0;
      rd_j_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_i_q      <= rd_i_d;
      rd_j_q      <= rd_j_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank_q][wr_cnt_q] <= in_data;
  end

  // Synchronous read port doubles as the output data register; it only
  // loads on rd_en, so data holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset)      out_data_q <= '0;
    else if (rd_en) out_data_q <= mem_q[rd_bank_q][rd_addr];
  end

endmodule

// File: tb/tb_transpose_pingpong_buffer.sv
// Scoreboard bench: stimulus pushes expected transposed elements, per-instance
// monitors pop and compare on every output transfer.
module tb_transpose_pingpong_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int   errors = 0;
  int   checks = 0;
  int   bubbles = 0;
  bit   gap_arm = 1'b0;

  // DIM=4, 8-bit instance
  logic       rst4, iv4, ir4, ov4, or4, ol4;
  logic [7:0] id4, od4;
  // DIM=2, 16-bit instance
  logic        rst2, iv2, ir2, ov2, or2, ol2;
  logic [15:0] id2, od2;

  transpose_pingpong_buffer #(.DATA_WIDTH(8), .DIM(4)) u4 (
    .clk(clk), .reset(rst4), .in_data(id4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_valid(ov4), .out_ready(or4), .out_last(ol4));

  transpose_pingpong_buffer #(.DATA_WIDTH(16), .DIM(2)) u2 (
    .clk(clk), .reset(rst2), .in_data(id2), .in_valid(iv2), .in_ready(ir2),
    .out_data(od2), .out_valid(ov2), .out_ready(or2), .out_last(ol2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the DIM=4 instance, including stall-stability and bubble tracking.
  logic       stall4 = 1'b0;
  logic [7:0] sd4;
  logic       sl4;
  always @(negedge clk) begin
    if (rst4) stall4 = 1'b0;
    else begin
      if (stall4) begin
        chk("stall4_valid", 32'(ov4), 1);
        chk("stall4_data", 32'(od4), 32'(sd4));
        chk("stall4_last", 32'(ol4), 32'(sl4));
      end
      if (gap_arm && q4.size() != 0 && !ov4) bubbles++;
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("out4_unexpected", 0, 1);
        else begin
          exp_t e;
          e = q4.pop_front();
          chk("out4_data", 32'(od4), 32'(e.d[7:0]));
          chk("out4_last", 32'(ol4), 32'(e.l));
        end
      end
      stall4 = ov4 && !or4;
      sd4    = od4;
      sl4    = ol4;
    end
  end

  always @(negedge clk) begin
    if (!rst2 && ov2 && or2) begin
      if (q2.size() == 0) chk("out2_unexpected", 0, 1);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("out2_data", 32'(od2), 32'(e.d));
        chk("out2_last", 32'(ol2), 32'(e.l));
      end
    end
  end

  task automatic push4(input logic [7:0] v, output int st);
    id4 = v; iv4 = 1'b1; st = 0;
    while (!ir4 && st < 200) begin @(posedge clk); #1; st++; end
    chk("accept4", 32'(ir4), 1);
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic push2(input logic [15:0] v);
    int st = 0;
    id2 = v; iv2 = 1'b1;
    while (!ir2 && st < 200) begin @(posedge clk); #1; st++; end
    chk("accept2", 32'(ir2), 1);
    @(posedge clk); #1;
    iv2 = 1'b0;
  endtask

  // Expected column-major order of a DIM=4 tile whose element k = base+k.
  task automatic exp_tile4(input int base);
    exp_t e;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        e.d = 16'((base + j*4 + i) & 255);
        e.l = (i == 3) && (j == 3);
        q4.push_back(e);
      end
  endtask

  task automatic feed_tile4(input int base, output int stalls);
    int st;
    stalls = 0;
    for (int k = 0; k < 16; k++) begin
      push4(8'((base + k) & 255), st);
      stalls += st;
    end
  endtask

  task automatic drain4(input string name, input int budget);
    int n = 0;
    while (q4.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    chk(name, 32'(q4.size()), 0);
  endtask

  task automatic pulse_reset4();
    rst4 = 1'b1;
    q4.delete();
    @(posedge clk); #1;
    rst4 = 1'b0;
    chk("rst4_valid", 32'(ov4), 0);
    chk("rst4_last", 32'(ol4), 0);
    chk("rst4_ready", 32'(ir4), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp1[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int   st, stalls, n;
    exp_t e;
    bit   rnd_done;

    rst4 = 1'b1; iv4 = 1'b0; id4 = '0; or4 = 1'b1;
    rst2 = 1'b1; iv2 = 1'b0; id2 = '0; or2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0; rst2 = 1'b0;
    chk("reset_valid4", 32'(ov4), 0);
    chk("reset_last4", 32'(ol4), 0);
    chk("reset_data4", 32'(od4), 0);
    chk("reset_ready4", 32'(ir4), 1);
    chk("reset_valid2", 32'(ov2), 0);
    chk("reset_ready2", 32'(ir2), 1);

    // Single tile, hand-computed transpose order, latency check.
    for (int k = 0; k < 16; k++) begin
      e.d = 16'(exp1[k]); e.l = (k == 15);
      q4.push_back(e);
    end
    feed_tile4(0, stalls);
    chk("t1_stalls", 32'(stalls), 0);
    chk("t1_valid_at_E", 32'(ov4), 0);
    @(posedge clk); #1;
    chk("t1_valid_at_E1", 32'(ov4), 1);
    chk("t1_first_data", 32'(od4), 0);
    drain4("t1_drain", 50);

    // Three continuous tiles: no input stalls, no output bubbles.
    exp_tile4(0); exp_tile4(16); exp_tile4(32);
    stalls = 0;
    fork
      begin
        for (int t = 0; t < 3; t++) begin
          feed_tile4(t*16, st);
          stalls += st;
        end
      end
      begin
        n = 0;
        while (!ov4 && n < 100) begin @(posedge clk); #1; n++; end
        bubbles = 0;
        gap_arm = 1'b1;
      end
    join
    drain4("t2_drain", 100);
    gap_arm = 1'b0;
    chk("t2_stalls", 32'(stalls), 0);
    chk("t2_bubbles", 32'(bubbles), 0);

    // Back-pressure: both banks fill, input held, output stable.
    or4 = 1'b0;
    exp_tile4(0); exp_tile4(16);
    stalls = 0;
    for (int k = 0; k < 32; k++) begin
      push4(8'(k), st);
      stalls += st;
    end
    chk("t3_stalls", 32'(stalls), 0);
    chk("t3_ready_drop", 32'(ir4), 0);
    chk("t3_valid_held", 32'(ov4), 1);
    chk("t3_data_held", 32'(od4), 0);
    id4 = 8'd32; iv4 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_ready_still0", 32'(ir4), 0);
    chk("t3_data_still0", 32'(od4), 0);
    or4 = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("t3_ready_before_free", 32'(ir4), 0);
    @(posedge clk); #1;
    chk("t3_ready_after_free", 32'(ir4), 1);
    @(posedge clk); #1;
    iv4 = 1'b0;
    for (int k = 33; k < 42; k++) push4(8'(k), st);
    drain4("t3_drain", 100);

    // Reset with a 10-element partial tile, then a fresh tile.
    pulse_reset4();
    exp_tile4(100);
    feed_tile4(100, st);
    drain4("t5a_drain", 50);

    // Reset while draining, then a fresh tile must show no stale data.
    exp_tile4(200);
    feed_tile4(200, st);
    n = 0;
    while (q4.size() > 10 && n < 50) begin @(posedge clk); #1; n++; end
    pulse_reset4();
    exp_tile4(100);
    feed_tile4(100, st);
    drain4("t5b_drain", 50);

    // Random input gaps and random output back-pressure over 20 tiles.
    rnd_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 20; t++) begin
          exp_tile4(t*16);
          for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) == 0) begin iv4 = 1'b0; @(posedge clk); #1; end
            push4(8'((t*16 + k) & 255), st);
          end
        end
        drain4("t4_drain", 2000);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          or4 = 1'($urandom_range(0, 1));
        end
      end
    join
    or4 = 1'b1;

    // DIM=2, 16-bit tile.
    e.d = 16'h000A; e.l = 1'b0; q2.push_back(e);
    e.d = 16'h000C; e.l = 1'b0; q2.push_back(e);
    e.d = 16'h000B; e.l = 1'b0; q2.push_back(e);
    e.d = 16'h000D; e.l = 1'b1; q2.push_back(e);
    push2(16'h000A); push2(16'h000B); push2(16'h000C); push2(16'h000D);
    n = 0;
    while (q2.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t6_drain", 32'(q2.size()), 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
